mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_rsp_pkg.sv | 20 ++
 rtl/mem_rsp_array.sv | 30 +++
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the mem_responder slice.
// Build option: MEM_RSP_BYTE_EN_EN enables the req_be byte-lane write mask.
package mem_rsp_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BYTES_W = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Misaligned or word index beyond the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/mem_rsp_array.sv
// Single-port word storage: synchronous byte-masked write, combinational read.
// Contents are never reset.
module mem_rsp_array
    import mem_rsp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [WORD_W-1:0]              wdata_i,
    input  logic [BYTES_W-1:0]             be_i,
    output logic [WORD_W-1:0]              rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < BYTES_W; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Request/response memory responder with a programmable wait-state count.
// Build option: MEM_RSP_BYTE_EN_EN adds the req_be port and per-lane writes.
module mem_responder
    import mem_rsp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
`ifdef MEM_RSP_BYTE_EN_EN
    input  logic [3:0]         req_be,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q;
    logic [31:0]         addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
`ifdef MEM_RSP_BYTE_EN_EN
    logic [BYTES_W-1:0]  be_q;
`endif

    logic                accept;
    logic                enter_resp;
    logic                cur_wr;
    logic                cur_err;
    logic [31:0]         cur_addr;
    logic [WORD_W-1:0]   cur_wdata;
    logic [BYTES_W-1:0]  cur_be;
    logic [WORD_W-1:0]   mem_rdata;
    logic                mem_we;

    // With zero wait states RESP is entered on the accept edge itself, so the
    // live request feeds the array then; otherwise the captured copy does.
    always_comb begin
        if (state_q == IDLE) begin
            cur_wr    = req_wr;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
`ifdef MEM_RSP_BYTE_EN_EN
            cur_be    = req_be;
`else
            cur_be    = '1;
`endif
        end else begin
            cur_wr    = wr_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
`ifdef MEM_RSP_BYTE_EN_EN
            cur_be    = be_q;
`else
            cur_be    = '1;
`endif
        end
        cur_err = addr_err(cur_addr, DEPTH_WORDS);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_wr || cur_err) ? '0 : mem_rdata;
        end
    end

    // Gated by reset so an edge seen while reset is low can never write.
    assign mem_we = enter_resp && cur_wr && !cur_err && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_RSP_BYTE_EN_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
`ifdef MEM_RSP_BYTE_EN_EN
                be_q    <= req_be;
`endif
            end
        end
    end

    mem_rsp_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .be_i    (cur_be),
        .rdata_o (mem_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: u_dut_a with WAIT_CYCLES=2, u_dut_b with WAIT_CYCLES=0.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1;
    logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        rst_b = 1'b1;
    logic        b_req_valid = 1'b0, b_req_wr = 1'b0, b_rsp_ready = 1'b0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
`ifdef MEM_RSP_BYTE_EN_EN
    logic [3:0]  req_be = 4'hF;
    logic [3:0]  b_req_be = 4'hF;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(rst_a),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_RSP_BYTE_EN_EN
        .req_be(req_be),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(rst_b),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
`ifdef MEM_RSP_BYTE_EN_EN
        .req_be(b_req_be),
`endif
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the response handshake.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] rdata, output logic err,
                       output int lat);
        int guard;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, rdata);
            check("hold_err", {31'd0, rsp_err}, {31'd0, err});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_hs_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        #1 rst_a = 1'b0; rst_b = 1'b0;
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_b_ready", {31'd0, b_req_ready}, 32'd1);
        @(negedge clk) begin rst_a = 1'b1; rst_b = 1'b1; end
        @(posedge clk); #1;

        txn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        check("wr10_lat", lat, 32'd3);
        check("wr10_err", {31'd0, er}, 32'd0);
        check("wr10_rdata", rd, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        check("rd10_lat", lat, 32'd3);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_err", {31'd0, er}, 32'd0);

        txn(1'b0, 32'h13, 32'h0, 0, rd, er, lat);
        check("rd13_err", {31'd0, er}, 32'd1);
        check("rd13_data", rd, 32'd0);
        txn(1'b0, 32'h400, 32'h0, 0, rd, er, lat);
        check("rd400_err", {31'd0, er}, 32'd1);
        check("rd400_data", rd, 32'd0);

        txn(1'b1, 32'h0, 32'h01020304, 0, rd, er, lat);
        txn(1'b1, 32'h400, 32'h55555555, 0, rd, er, lat);
        check("wr400_err", {31'd0, er}, 32'd1);
        txn(1'b1, 32'h11, 32'h66666666, 0, rd, er, lat);
        check("wr11_err", {31'd0, er}, 32'd1);
        txn(1'b0, 32'h0, 32'h0, 0, rd, er, lat);
        check("rd0_no_alias", rd, 32'h01020304);
        txn(1'b1, 32'h3FC, 32'hA5A5F00F, 0, rd, er, lat);
        check("wr3fc_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h3FC, 32'h0, 0, rd, er, lat);
        check("rd3fc_data", rd, 32'hA5A5F00F);
        check("rd3fc_err", {31'd0, er}, 32'd0);

        txn(1'b0, 32'h10, 32'h0, 5, rd, er, lat);
        check("hold_rd10_data", rd, 32'hDEADBEEF);
        check("hold_rd10_lat", lat, 32'd3);

        txn(1'b1, 32'h20, 32'h0BADF00D, 0, rd, er, lat);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_wait", {31'd0, req_ready}, 32'd0);
        #2 rst_a = 1'b0;
        #1;
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rdata", rsp_rdata, 32'd0);
        check("abort_err", {31'd0, rsp_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_a = 1'b1;
        @(posedge clk); #1;
        check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        txn(1'b0, 32'h20, 32'h0, 0, rd, er, lat);
        check("rd20_kept", rd, 32'h0BADF00D);
        txn(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        check("rd10_unchanged", rd, 32'hDEADBEEF);

`ifdef MEM_RSP_BYTE_EN_EN
        txn(1'b1, 32'h30, 32'h11223344, 0, rd, er, lat);
        req_be = 4'b0101;
        txn(1'b1, 32'h30, 32'hAABBCCDD, 0, rd, er, lat);
        req_be = 4'b0000;
        txn(1'b1, 32'h30, 32'h99999999, 0, rd, er, lat);
        check("be0_err", {31'd0, er}, 32'd0);
        req_be = 4'hF;
        txn(1'b0, 32'h30, 32'h0, 0, rd, er, lat);
        check("be_merge", rd, 32'h11BB33DD);
`endif

        b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 32'h8;
        b_req_wdata = 32'hCAFEF00D; b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("b_wr_lat1", {31'd0, b_rsp_valid}, 32'd1);
        check("b_wr_err", {31'd0, b_rsp_err}, 32'd0);
        b_req_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic exp_v;
            exp_v = (i % 2) == 1;
            @(posedge clk); #1;
            check("b_stream_valid", {31'd0, b_rsp_valid}, {31'd0, exp_v});
            check("b_stream_ready", {31'd0, b_req_ready}, {31'd0, !exp_v});
            if (exp_v) begin
                check("b_stream_rdata", b_rsp_rdata, 32'hCAFEF00D);
                check("b_stream_err", {31'd0, b_rsp_err}, 32'd0);
            end
        end
        b_req_valid = 1'b0;
        @(posedge clk); #1;
        check("b_stream_end", {31'd0, b_rsp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
